// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit-side buffering blocks.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered level/full/empty, sticky overflow
// and a registered read byte that updates only on pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int AW     = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              clr_ovf,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       level_reg;
    logic [AW:0]       level_next;
    logic              full_reg;
    logic              empty_reg;
    logic              overflow_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              push_ok;
    logic              pop_ok;

    // Acceptance uses the registered full flag; a same-cycle pop never makes room.
    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        level_next = level_reg;
        if (push_ok && !pop_ok) begin
            level_next = level_reg + LVL_ONE;
        end else if (!push_ok && pop_ok) begin
            level_next = level_reg - LVL_ONE;
        end
    end

    always_ff @(posedge clk1) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            level_reg <= level_next;
            full_reg  <= (level_next == LVL_FULL);
            empty_reg <= (level_next == '0);
            // A dropped byte beats a simultaneous clear so no loss goes unreported.
            if (push && full_reg) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter: launches one byte per
// completion edge with a single-cycle strobe, holding data until done.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int AW     = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              busy,
    output logic              wr_data,
    output logic [DATA_W-1:0] data,
    input  logic              donet
);

    tx_state_e state_reg;
    tx_state_e state_next;
    logic      wr_data_reg;
    logic      wr_data_next;
    logic      busy_reg;
    logic      busy_next;
    logic      donet_q_reg;
    logic      done_ev;
    logic      pop;
    logic      fifo_empty;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk1      (clk1),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .clr_ovf   (clr_ovf),
        .pop       (pop),
        .full      (full),
        .empty     (fifo_empty),
        .level     (level),
        .overflow  (overflow),
        .rd_data   (data)
    );

    // Only rising edges count, so a level-held donet releases a single byte.
    assign done_ev = donet && !donet_q_reg;

    always_comb begin
        state_next   = state_reg;
        wr_data_next = 1'b0;
        busy_next    = busy_reg;
        pop          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    wr_data_next = 1'b1;
                    busy_next    = 1'b1;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_ev) begin
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            wr_data_reg <= 1'b0;
            busy_reg    <= 1'b0;
            donet_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_data_reg <= wr_data_next;
            busy_reg    <= busy_next;
            donet_q_reg <= donet;
        end
    end

    assign empty   = fifo_empty;
    assign busy    = busy_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and launch controller directly upstream of the UART transmitter, in the clk1 (transmit) domain.
- Host pushes bytes at any rate into a DEPTH-entry FIFO.
- Block hands bytes to the transmitter one at a time: one-cycle wr_data strobe with data held stable, then waits for donet before launching the next byte.
- Lets software queue whole messages instead of pacing each byte against donet.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).
- DATA_W, 8, byte width; fixed to 8 to match the transmitter.

Ports:
- clk1  input  1  transmit-domain clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- push  input  1  host write strobe; one byte per cycle when high.
- push_data  input  8  byte written on push.
- clr_ovf  input  1  clears the sticky overflow flag.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  AW+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky; a push was dropped.
- busy  output  1  a byte has been launched and donet is not yet seen.
- wr_data  output  1  one-cycle launch strobe to transmitter.
- data  output  8  byte to transmitter; stable from wr_data until donet.
- donet  input  1  transmitter completion indication; level or pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and level = 0; empty = 1, full = 0.
  - overflow = 0, wr_data = 0, data = 8'h00, busy = 0.
  - State = IDLE; donet edge register = 0.
  - Memory contents are don't-care.
  - Reset mid-transfer discards all queued bytes and any in-flight launch. The transmitter is reset by the same rst.
- Push:
  - Accepted iff push && !full, with full taken as the registered value at the start of the cycle.
  - A same-cycle pop does not make room.
  - Accepted: mem[wr_ptr] <= push_data, wr_ptr++ (wraps modulo DEPTH).
  - Rejected: byte dropped, overflow <= 1.
- overflow: clr_ovf clears it. If clr_ovf and a rejected push occur in the same cycle, set wins.
- level: +1 on accepted push, -1 on pop, unchanged when both occur in the same cycle. full = (level == DEPTH); empty = (level == 0). All are registered.
- donet edge detect: donet_q <= donet; done_ev = donet && !donet_q. Only rising edges count, so a level-held donet launches exactly one byte.
- State machine, 2 states:
  - IDLE:
    - If !empty, pop: data <= mem[rd_ptr], rd_ptr++ (wraps), wr_data <= 1, busy <= 1, state <= WAIT.
    - Else wr_data <= 0.
  - WAIT:
    - wr_data <= 0, so the strobe lasts exactly one cycle; data holds.
    - On done_ev: busy <= 0, state <= IDLE.
    - No timeout.
- Latency:
  - Push accepted in cycle N into an empty FIFO, idle controller: level = 1 in N+1, wr_data high in N+2 only.
  - After done_ev in cycle M with FIFO non-empty: IDLE in M+1, next wr_data in M+2. Minimum one idle cycle between launches.
- done_ev in IDLE is ignored, with no state change.
- data changes only on a pop. Between launches it holds the last byte sent.
- Wrap-around: pointers wrap silently. Fill/drain across the wrap boundary must preserve order.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - State encodings ST_IDLE = 1'b0, ST_WAIT = 1'b1.
  - Default FIFO depth constant.
- One sub-module, uart_sync_fifo:
  - Holds the memory, pointers, level, full/empty, push acceptance and overflow.
  - Exposes a pop strobe and a registered read byte.
- uart_tx_fifo keeps the edge detector and the launch FSM.

Test Plan:
- Single byte: reset, push 8'hA5 in cycle 5 → wr_data high in cycle 7 only, data = 8'hA5, busy = 1 until donet pulse; next wr_data only after further pushes.
- Burst order: push 8'h01..8'h05 back to back, pulse donet 10 cycles after each launch → exactly five wr_data strobes carrying 01,02,03,04,05 in order; level returns to 0, empty = 1.
- Full and overflow:
  - Hold donet low and push 18 bytes with DEPTH = 16. One byte is popped into data, so 16 remain queued; the 18th push is dropped, full = 1, overflow = 1.
  - clr_ovf → overflow = 0.
  - Same-cycle clr_ovf and rejected push → overflow stays 1.
- Level-held donet: hold donet high for 20 cycles after the first launch with 3 bytes queued → exactly one additional launch per rising edge; no back-to-back launches while donet is held.
- Wrap: DEPTH = 4, push 3, drain 3, push 4 (pointers cross the wrap) → output order matches push order; full asserts at level 4.
- Reset mid-operation: drive rst low during WAIT with 5 bytes queued → all outputs return to reset values asynchronously, before the next clk1 edge; after release there are no wr_data strobes until a new push.
